test_data_checker: RTL and testbench

TEST_DATA_CHECKER -- requirements
Module: test_data_checker

---
 rtl/test_data_checker.sv | 155 +++++++++++++++
 tb/tb_test_data_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/test_data_checker.sv
// Checks a free-running counting test pattern (0..WRAP_VALUE, then 0 again),
// acquires lock after LOCK_COUNT in-sequence samples and counts errors and wraps.
module test_data_checker #(
  parameter logic [9:0] WRAP_VALUE = 10'd1020,
  parameter int         LOCK_COUNT = 4
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        enable,
  input  logic [9:0]  dataIn,
  input  logic        dataValid,
  input  logic        clearCounters,
  output logic        locked,
  output logic        errorFlag,
  output logic [15:0] errorCount,
  output logic [15:0] wrapCount
);

  localparam int              RUN_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN   = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] ONE_RUN    = RUN_W'(1);
  localparam bit              SEED_LOCKS = (LOCK_COUNT <= 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  state_t           w_reseedState;
  logic [9:0]       r_expected;
  logic [9:0]       w_expectedNext;
  logic [9:0]       w_seed;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_runNext;
  logic             w_inRange;
  logic             w_match;
  logic             w_atLock;
  logic             w_errorEvent;
  logic             w_wrapEvent;
  logic             r_locked;
  logic             r_errorFlag;
  logic [15:0]      r_errorCount;
  logic [15:0]      r_wrapCount;

  // Samples above WRAP_VALUE can never be part of the pattern.
  assign w_inRange     = (dataIn <= WRAP_VALUE);
  assign w_match       = w_inRange && (dataIn == r_expected);
  assign w_seed        = (dataIn == WRAP_VALUE) ? 10'd0 : (dataIn + 10'd1);
  assign w_atLock      = (r_run >= (LOCK_RUN - ONE_RUN));
  assign w_reseedState = SEED_LOCKS ? LOCKED : ACQUIRE;

  // Next-state logic. An out-of-range sample outside IDLE drops back to IDLE
  // so the next in-range sample seeds afresh instead of a bogus expected value.
  always_comb begin
    w_stateNext    = r_state;
    w_expectedNext = r_expected;
    w_runNext      = r_run;
    w_errorEvent   = 1'b0;
    w_wrapEvent    = 1'b0;
    if (!enable) begin
      w_stateNext = IDLE;
      w_runNext   = '0;
    end else if (dataValid) begin
      case (r_state)
        IDLE: begin
          if (w_inRange) begin
            w_expectedNext = w_seed;
            w_runNext      = ONE_RUN;
            w_stateNext    = w_reseedState;
          end
        end
        ACQUIRE: begin
          if (w_match) begin
            w_expectedNext = w_seed;
            if (w_atLock) begin
              w_runNext   = LOCK_RUN;
              w_stateNext = LOCKED;
            end else begin
              w_runNext = r_run + ONE_RUN;
            end
          end else if (w_inRange) begin
            w_expectedNext = w_seed;
            w_runNext      = ONE_RUN;
            w_stateNext    = w_reseedState;
          end else begin
            w_runNext   = '0;
            w_stateNext = IDLE;
          end
        end
        LOCKED: begin
          if (w_match) begin
            w_expectedNext = w_seed;
            w_wrapEvent    = (dataIn == 10'd0);
          end else begin
            w_errorEvent = 1'b1;
            if (w_inRange) begin
              w_expectedNext = w_seed;
              w_runNext      = ONE_RUN;
              w_stateNext    = w_reseedState;
            end else begin
              w_runNext   = '0;
              w_stateNext = IDLE;
            end
          end
        end
        default: begin
          w_stateNext = IDLE;
          w_runNext   = '0;
        end
      endcase
    end
  end

  // State and counters; a clear request wins over a same-cycle error or wrap.
  always_ff @(posedge clock) begin
    if (!nReset) begin
      r_state      <= IDLE;
      r_expected   <= '0;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_errorFlag  <= 1'b0;
      r_errorCount <= '0;
      r_wrapCount  <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_expected <= w_expectedNext;
      r_run      <= w_runNext;
      r_locked   <= (w_stateNext == LOCKED);
      if (clearCounters) begin
        r_errorFlag  <= 1'b0;
        r_errorCount <= '0;
        r_wrapCount  <= '0;
      end else begin
        if (w_errorEvent) begin
          r_errorFlag <= 1'b1;
          if (r_errorCount != 16'hFFFF) begin
            r_errorCount <= r_errorCount + 16'd1;
          end
        end
        if (w_wrapEvent) begin
          r_wrapCount <= r_wrapCount + 16'd1;
        end
      end
    end
  end

  assign locked     = r_locked;
  assign errorFlag  = r_errorFlag;
  assign errorCount = r_errorCount;
  assign wrapCount  = r_wrapCount;

endmodule

// File: tb/tb_test_data_checker.sv
// Bench for test_data_checker: directed scenarios plus random traffic compared
// against a streak-based model; a second instance with LOCK_COUNT=1 saturates errorCount.
module tb_test_data_checker;

  localparam int WRAP = 1020;
  localparam int LOCKN = 4;

  logic        clock = 1'b0;
  logic        nReset, enable, dataValid, clearCounters;
  logic [9:0]  dataIn;
  logic        locked, errorFlag;
  logic [15:0] errorCount, wrapCount;

  logic        sReset, sEnable, sValid, sClear;
  logic [9:0]  sData;
  logic        sLocked, sFlag;
  logic [15:0] sErrors, sWraps;

  int checks = 0;
  int errors = 0;

  // Reference model: length of the current in-sequence streak and the last sample.
  int mStreak = 0;
  int mLast = 0;
  int mErrors = 0;
  int mWraps = 0;
  bit mFlag = 1'b0;

  test_data_checker #(.WRAP_VALUE(10'd1020), .LOCK_COUNT(LOCKN)) dut (
    .clock(clock), .nReset(nReset), .enable(enable), .dataIn(dataIn),
    .dataValid(dataValid), .clearCounters(clearCounters), .locked(locked),
    .errorFlag(errorFlag), .errorCount(errorCount), .wrapCount(wrapCount)
  );

  test_data_checker #(.WRAP_VALUE(10'd1020), .LOCK_COUNT(1)) dutSat (
    .clock(clock), .nReset(sReset), .enable(sEnable), .dataIn(sData),
    .dataValid(sValid), .clearCounters(sClear), .locked(sLocked),
    .errorFlag(sFlag), .errorCount(sErrors), .wrapCount(sWraps)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic updateModel(input bit rstN, input bit en, input int din, input bit dv, input bit clr);
    bit wasLocked, inRange, inSeq, evErr, evWrap;
    int nextOfLast;
    evErr = 1'b0;
    evWrap = 1'b0;
    if (!rstN) begin
      mStreak = 0; mLast = 0; mErrors = 0; mWraps = 0; mFlag = 1'b0;
      return;
    end
    if (!en) begin
      mStreak = 0;
    end else if (dv) begin
      inRange = (din <= WRAP);
      wasLocked = (mStreak >= LOCKN);
      nextOfLast = (mLast + 1) % (WRAP + 1);
      inSeq = (mStreak > 0) && inRange && (din == nextOfLast);
      if (inSeq) begin
        mStreak++;
        evWrap = wasLocked && (din == 0);
      end else begin
        evErr = wasLocked;
        mStreak = inRange ? 1 : 0;
      end
      mLast = din;
    end
    if (clr) begin
      mErrors = 0; mWraps = 0; mFlag = 1'b0;
    end else begin
      if (evErr) begin
        mFlag = 1'b1;
        if (mErrors < 65535) mErrors++;
      end
      if (evWrap) mWraps = (mWraps + 1) % 65536;
    end
  endtask

  task automatic applyStimulus(input bit rstN, input bit en, input int din, input bit dv, input bit clr);
    nReset = rstN;
    enable = en;
    dataIn = 10'(din);
    dataValid = dv;
    clearCounters = clr;
    @(posedge clock);
    updateModel(rstN, en, din, dv, clr);
    #1;
    checkOutput("locked", {31'd0, locked}, {31'd0, mStreak >= LOCKN});
    checkOutput("errorFlag", {31'd0, errorFlag}, {31'd0, mFlag});
    checkOutput("errorCount", {16'd0, errorCount}, 32'(mErrors));
    checkOutput("wrapCount", {16'd0, wrapCount}, 32'(mWraps));
  endtask

  task automatic feed(input int v);
    applyStimulus(1'b1, 1'b1, v, 1'b1, 1'b0);
  endtask

  task automatic mainTest();
    int seqVal;
    bit rstN, en, dv, clr;
    int din;
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0);
    checkOutput("rstLocked", {31'd0, locked}, 32'd0);
    checkOutput("rstErrCount", {16'd0, errorCount}, 32'd0);
    checkOutput("rstWrap", {16'd0, wrapCount}, 32'd0);

    // Basic acquisition 0,1,2,3
    feed(0); feed(1); feed(2);
    checkOutput("acqNotYet", {31'd0, locked}, 32'd0);
    feed(3);
    checkOutput("lockAfter3", {31'd0, locked}, 32'd1);
    checkOutput("noErrAfter3", {16'd0, errorCount}, 32'd0);

    // Wrap across WRAP_VALUE
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0);
    for (int v = 1015; v <= 1018; v++) feed(v);
    checkOutput("lockAt1018", {31'd0, locked}, 32'd1);
    feed(1019); feed(1020);
    checkOutput("wrapBefore0", {16'd0, wrapCount}, 32'd0);
    feed(0);
    checkOutput("wrapAfter0", {16'd0, wrapCount}, 32'd1);
    feed(1);
    checkOutput("wrapNoErr", {16'd0, errorCount}, 32'd0);

    // Break in sequence while locked
    for (int v = 2; v <= 11; v++) feed(v);
    feed(50);
    checkOutput("errCount50", {16'd0, errorCount}, 32'd1);
    checkOutput("errFlag50", {31'd0, errorFlag}, 32'd1);
    checkOutput("unlock50", {31'd0, locked}, 32'd0);
    feed(51); feed(52);
    checkOutput("unlock52", {31'd0, locked}, 32'd0);
    feed(53);
    checkOutput("relock53", {31'd0, locked}, 32'd1);

    // Clear coincident with a mismatch
    applyStimulus(1'b1, 1'b1, 200, 1'b1, 1'b1);
    checkOutput("clrErrCount", {16'd0, errorCount}, 32'd0);
    checkOutput("clrErrFlag", {31'd0, errorFlag}, 32'd0);
    checkOutput("clrUnlock", {31'd0, locked}, 32'd0);
    feed(201); feed(202); feed(203);
    checkOutput("clrAcqRelock", {31'd0, locked}, 32'd1);

    // Three errors then a mid-sequence reset
    for (int e = 0; e < 3; e++) begin
      feed(300 + 100 * e);
      for (int k = 1; k <= 3; k++) feed(300 + 100 * e + k);
    end
    checkOutput("threeErrors", {16'd0, errorCount}, 32'd3);
    checkOutput("lockedBeforeRst", {31'd0, locked}, 32'd1);
    applyStimulus(1'b0, 1'b1, 504, 1'b1, 1'b0);
    checkOutput("rst2Locked", {31'd0, locked}, 32'd0);
    checkOutput("rst2ErrCount", {16'd0, errorCount}, 32'd0);
    checkOutput("rst2Flag", {31'd0, errorFlag}, 32'd0);
    feed(500); feed(501); feed(502);
    checkOutput("rst2NotYet", {31'd0, locked}, 32'd0);
    feed(503);
    checkOutput("rst2Relock", {31'd0, locked}, 32'd1);

    // Disable holds counters and drops lock
    feed(700); feed(701); feed(702); feed(703);
    applyStimulus(1'b1, 1'b0, 999, 1'b1, 1'b0);
    checkOutput("disUnlock", {31'd0, locked}, 32'd0);
    checkOutput("disHoldErr", {16'd0, errorCount}, 32'd1);
    checkOutput("disHoldFlag", {31'd0, errorFlag}, 32'd1);
    feed(704); feed(705); feed(706);
    checkOutput("disNotYet", {31'd0, locked}, 32'd0);
    feed(707);
    checkOutput("disRelock", {31'd0, locked}, 32'd1);
    applyStimulus(1'b1, 1'b1, 900, 1'b0, 1'b0);
    feed(708);
    checkOutput("gapNoErr", {16'd0, errorCount}, 32'd1);

    // Out-of-range samples never seed
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0);
    feed(1023); feed(0); feed(1); feed(2);
    checkOutput("oorNotYet", {31'd0, locked}, 32'd0);
    feed(3);
    checkOutput("oorLock", {31'd0, locked}, 32'd1);

    // Random traffic
    seqVal = 1000;
    for (int i = 0; i < 4000; i++) begin
      rstN = ($urandom_range(0, 499) != 0);
      en = ($urandom_range(0, 59) != 0);
      dv = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 79) == 0);
      case ($urandom_range(0, 39))
        0: din = $urandom_range(0, 1023);
        1: din = $urandom_range(1005, 1020);
        default: din = (seqVal + 1) % (WRAP + 1);
      endcase
      applyStimulus(rstN, en, din, dv, clr);
      if (dv && din <= WRAP) seqVal = din;
    end
  endtask

  task automatic satTest();
    sReset = 1'b0; sEnable = 1'b1; sValid = 1'b0; sClear = 1'b0; sData = 10'd0;
    @(posedge clock);
    #1;
    sReset = 1'b1;
    sValid = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("satSeedLock", {31'd0, sLocked}, 32'd1);
    checkOutput("satSeedNoErr", {16'd0, sErrors}, 32'd0);
    for (int i = 1; i <= 65537; i++) begin
      @(posedge clock);
      #1;
      if (i == 3) begin
        checkOutput("satErr3", {16'd0, sErrors}, 32'd3);
        checkOutput("satFlag", {31'd0, sFlag}, 32'd1);
      end
      if (i == 65534) checkOutput("satErrFFFE", {16'd0, sErrors}, 32'h0000FFFE);
      if (i == 65535) checkOutput("satErrFFFF", {16'd0, sErrors}, 32'h0000FFFF);
      if (i == 65537) checkOutput("satHold", {16'd0, sErrors}, 32'h0000FFFF);
    end
  endtask

  initial begin
    nReset = 1'b0; enable = 1'b0; dataIn = 10'd0; dataValid = 1'b0; clearCounters = 1'b0;
    #1;
    fork
      mainTest();
      satTest();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
